// File: rtl/exhaustive_sweep_ctrl.sv
// Exhaustive stimulus sequencer: walks dut_n through 0..2^WIDTH-1, captures
// each response into a MISR and streams (pattern, response) records out.
module exhaustive_sweep_ctrl #(
    parameter int              WIDTH  = 5,
    parameter int              OUT_W  = 1,
    parameter int              SETTLE = 1,
    parameter int              SIG_W  = 16,
    parameter logic [SIG_W-1:0] POLY  = 16'h1021
) (
    input  logic             CK,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    output logic [WIDTH-1:0] dut_n,
    input  logic [OUT_W-1:0] dut_resp,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [WIDTH-1:0] rec_pattern,
    output logic [OUT_W-1:0] rec_resp,
    output logic [SIG_W-1:0] signature,
    output logic [WIDTH:0]   rec_count,
    output logic             busy,
    output logic             done
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] SETTLE_M1 = CW'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_CAPTURE,
        S_EMIT,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_dut_n;
    logic [CW-1:0]    r_cnt;
    logic             r_valid;
    logic [WIDTH-1:0] r_pat;
    logic [OUT_W-1:0] r_resp;
    logic [SIG_W-1:0] r_sig;
    logic [WIDTH:0]   r_count;

    state_t           w_state;
    logic [WIDTH-1:0] w_dut_n;
    logic [CW-1:0]    w_cnt;
    logic             w_valid;
    logic [WIDTH-1:0] w_pat;
    logic [OUT_W-1:0] w_resp;
    logic [SIG_W-1:0] w_sig;
    logic [WIDTH:0]   w_count;
    logic [SIG_W-1:0] w_sig_fold;
    logic             w_last;

    // MISR step: shift, feed back POLY on MSB carry-out, xor in the response
    assign w_sig_fold = (r_sig << 1)
                      ^ (r_sig[SIG_W-1] ? POLY : '0)
                      ^ SIG_W'(dut_resp);
    assign w_last     = &r_dut_n;

    always_ff @(posedge CK) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_dut_n <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_pat   <= '0;
            r_resp  <= '0;
            r_sig   <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state;
            r_dut_n <= w_dut_n;
            r_cnt   <= w_cnt;
            r_valid <= w_valid;
            r_pat   <= w_pat;
            r_resp  <= w_resp;
            r_sig   <= w_sig;
            r_count <= w_count;
        end
    end

    always_comb begin
        w_state = r_state;
        w_dut_n = r_dut_n;
        w_cnt   = r_cnt;
        w_valid = r_valid;
        w_pat   = r_pat;
        w_resp  = r_resp;
        w_sig   = r_sig;
        w_count = r_count;
        if (abort) begin
            // signature, count and pattern are left for inspection
            w_state = S_IDLE;
            w_valid = 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        w_state = S_SETTLE;
                        w_dut_n = '0;
                        w_sig   = '0;
                        w_count = '0;
                        w_cnt   = SETTLE_M1;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == '0) begin
                        w_state = S_CAPTURE;
                    end else begin
                        w_cnt = r_cnt - CW'(1);
                    end
                end
                S_CAPTURE: begin
                    w_state = S_EMIT;
                    w_pat   = r_dut_n;
                    w_resp  = dut_resp;
                    w_sig   = w_sig_fold;
                    w_valid = 1'b1;
                end
                S_EMIT: begin
                    if (rec_ready) begin
                        w_count = r_count + (WIDTH+1)'(1);
                        w_valid = 1'b0;
                        if (w_last) begin
                            w_state = S_DONE;
                        end else begin
                            w_state = S_SETTLE;
                            w_dut_n = r_dut_n + WIDTH'(1);
                            w_cnt   = SETTLE_M1;
                        end
                    end
                end
                default: w_state = S_IDLE;
            endcase
        end
    end

    assign dut_n       = r_dut_n;
    assign rec_valid   = r_valid;
    assign rec_pattern = r_pat;
    assign rec_resp    = r_resp;
    assign signature   = r_sig;
    assign rec_count   = r_count;
    assign busy        = (r_state == S_SETTLE) || (r_state == S_CAPTURE)
                      || (r_state == S_EMIT);
    assign done        = (r_state == S_DONE);

endmodule

// File: tb/tb_exhaustive_sweep_ctrl.sv
// Bench for exhaustive_sweep_ctrl: two instances (default and SETTLE=4)
// checked against a record-level model of the sweep and its MISR.
module tb_exhaustive_sweep_ctrl;

    localparam int AW = 5;
    localparam int AS = 1;
    localparam int BW = 3;
    localparam int BO = 4;
    localparam int BS = 4;

    logic CK = 1'b0;
    logic reset = 1'b1;
    always #5 CK = ~CK;

    logic          a_start = 0, a_abort = 0, a_ready = 1;
    logic [AW-1:0] a_dut_n, a_pat;
    logic          a_resp, a_rresp, a_valid, a_busy, a_done;
    logic [15:0]   a_sig;
    logic [AW:0]   a_cnt;
    int            a_mode = 0;
    logic [31:0]   a_lut = '0;

    logic          b_start = 0, b_abort = 0, b_ready = 1;
    logic [BW-1:0] b_dut_n, b_pat;
    logic [BO-1:0] b_resp, b_rresp;
    logic          b_valid, b_busy, b_done;
    logic [15:0]   b_sig;
    logic [BW:0]   b_cnt;
    logic [BO-1:0] b_lut [8];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always_comb begin
        a_resp = 1'b0;
        case (a_mode)
            0: a_resp = 1'b0;
            1: a_resp = 1'b1;
            2: a_resp = ^a_dut_n;
            default: a_resp = a_lut[a_dut_n];
        endcase
    end

    assign b_resp = b_lut[b_dut_n];

    exhaustive_sweep_ctrl #(.WIDTH(AW), .OUT_W(1), .SETTLE(AS)) u_a (
        .CK(CK), .reset(reset), .start(a_start), .abort(a_abort),
        .dut_n(a_dut_n), .dut_resp(a_resp), .rec_valid(a_valid),
        .rec_ready(a_ready), .rec_pattern(a_pat), .rec_resp(a_rresp),
        .signature(a_sig), .rec_count(a_cnt), .busy(a_busy), .done(a_done)
    );

    exhaustive_sweep_ctrl #(.WIDTH(BW), .OUT_W(BO), .SETTLE(BS)) u_b (
        .CK(CK), .reset(reset), .start(b_start), .abort(b_abort),
        .dut_n(b_dut_n), .dut_resp(b_resp), .rec_valid(b_valid),
        .rec_ready(b_ready), .rec_pattern(b_pat), .rec_resp(b_rresp),
        .signature(b_sig), .rec_count(b_cnt), .busy(b_busy), .done(b_done)
    );

    task automatic step;
        @(posedge CK);
        #1;
        cyc++;
    endtask

    function automatic logic [15:0] misr(input logic [15:0] s, input int r);
        int t;
        t = (int'(s) * 2) % 65536;
        if (int'(s) >= 32768) t = t ^ 32'h1021;
        t = t ^ r;
        return t[15:0];
    endfunction

    function automatic int ref_a(input int mode, input int p);
        case (mode)
            0: return 0;
            1: return 1;
            2: return $countones(p) % 2;
            default: return int'(a_lut[p]);
        endcase
    endfunction

    task automatic test_reset;
        reset = 1'b1;
        step;
        reset = 1'b0;
        checks++;
        if (a_dut_n !== 0 || a_valid !== 0 || a_pat !== 0 || a_rresp !== 0) begin
            errors++;
            $display("FAIL reset_a_rec: dut_n=%0d valid=%b pat=%0d resp=%b, required all 0",
                     a_dut_n, a_valid, a_pat, a_rresp);
        end
        checks++;
        if (a_sig !== 0 || a_cnt !== 0 || a_busy !== 0 || a_done !== 0) begin
            errors++;
            $display("FAIL reset_a_stat: sig=%h cnt=%0d busy=%b done=%b, required all 0",
                     a_sig, a_cnt, a_busy, a_done);
        end
        checks++;
        if (b_dut_n !== 0 || b_valid !== 0 || b_sig !== 0 || b_cnt !== 0
            || b_busy !== 0 || b_done !== 0 || b_pat !== 0 || b_rresp !== 0) begin
            errors++;
            $display("FAIL reset_b: dut_n=%0d valid=%b sig=%h cnt=%0d busy=%b done=%b, required all 0",
                     b_dut_n, b_valid, b_sig, b_cnt, b_busy, b_done);
        end
    endtask

    // Full sweep on instance A with optional random ready and a 5-cycle stall
    task automatic a_sweep(input int mode, input int rnd, input int hold_pat,
                           input int timing);
        int acc = 0, ep = 0, chg = 0, first_v = -1, hold = 0, r;
        logic [15:0] es = '0;
        logic pv = 1'b0, stall = 1'b0;
        logic [AW-1:0] pdn, spat, sdn;
        logic srsp;
        a_mode = mode;
        if (mode == 3) a_lut = $urandom;
        a_ready = 1'b1;
        a_start = 1'b1;
        step;
        a_start = 1'b0;
        cyc = 0;
        pdn = a_dut_n;
        checks++;
        if (a_dut_n !== 0 || a_sig !== 0 || a_cnt !== 0 || a_busy !== 1 || a_done !== 0) begin
            errors++;
            $display("FAIL start_state: dut_n=%0d sig=%h cnt=%0d busy=%b done=%b, required 0 0 0 1 0",
                     a_dut_n, a_sig, a_cnt, a_busy, a_done);
        end
        while (!a_done && cyc < 3000) begin
            if (a_dut_n !== pdn) begin
                chg = cyc;
                pdn = a_dut_n;
            end
            if (stall) begin
                checks++;
                if (a_valid !== 1 || a_pat !== spat || a_rresp !== srsp || a_dut_n !== sdn) begin
                    errors++;
                    $display("FAIL stall_stable: valid=%b pat=%0d resp=%b dut_n=%0d, required 1 %0d %b %0d",
                             a_valid, a_pat, a_rresp, a_dut_n, spat, srsp, sdn);
                end
            end
            if (a_valid && !pv) begin
                if (first_v < 0) first_v = cyc;
                checks++;
                if (cyc - chg != AS + 1) begin
                    errors++;
                    $display("FAIL settle_lat_a: %0d cycles, required %0d", cyc - chg, AS + 1);
                end
            end
            if (a_valid && int'(a_pat) == hold_pat && hold == 0 && !stall) hold = 5;
            if (hold > 0) begin
                a_ready = 1'b0;
                hold--;
                if (hold == 0) hold = -1;
            end else begin
                a_ready = rnd != 0 ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            stall = a_valid && !a_ready;
            spat = a_pat;
            srsp = a_rresp;
            sdn = a_dut_n;
            if (a_valid && a_ready) begin
                r = ref_a(mode, ep);
                es = misr(es, r);
                checks++;
                if (a_pat !== AW'(ep) || a_rresp !== 1'(r) || a_sig !== es || a_cnt !== (AW+1)'(acc)) begin
                    errors++;
                    $display("FAIL record_a: pat=%0d resp=%b sig=%h cnt=%0d, required %0d %0d %h %0d",
                             a_pat, a_rresp, a_sig, a_cnt, ep, r, es, acc);
                end
                acc++;
                ep++;
            end
            pv = a_valid;
            step;
        end
        a_ready = 1'b1;
        checks++;
        if (!a_done) begin
            errors++;
            $display("FAIL sweep_timeout_a: done=%b after %0d cycles, required 1", a_done, cyc);
        end
        checks++;
        if (a_busy !== 0 || a_cnt !== 6'd32 || acc != 32 || a_sig !== es
            || a_dut_n !== 5'd31 || a_valid !== 0) begin
            errors++;
            $display("FAIL sweep_end_a: busy=%b cnt=%0d acc=%0d sig=%h dut_n=%0d valid=%b, required 0 32 32 %h 31 0",
                     a_busy, a_cnt, acc, a_sig, a_dut_n, a_valid, es);
        end
        if (timing != 0) begin
            checks++;
            if (first_v != AS + 1 || cyc != 32 * (AS + 2)) begin
                errors++;
                $display("FAIL sweep_timing_a: first_valid=%0d done_at=%0d, required %0d %0d",
                         first_v, cyc, AS + 1, 32 * (AS + 2));
            end
        end
    endtask

    task automatic test_sweep_zero;
        a_sweep(0, 0, -1, 1);
        checks++;
        if (a_sig !== 16'h0000) begin
            errors++;
            $display("FAIL zero_sig: sig=%h, required 0000", a_sig);
        end
    endtask

    task automatic test_sweep_ones;
        logic [15:0] seen [4];
        a_mode = 1;
        a_ready = 1'b1;
        a_start = 1'b1;
        step;
        a_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < AS + 2; c++) step;
            seen[k] = a_sig;
        end
        checks++;
        if (seen[0] !== 16'h0001 || seen[1] !== 16'h0003 || seen[2] !== 16'h0007 || seen[3] !== 16'h000f) begin
            errors++;
            $display("FAIL ones_sig_seq: %h %h %h %h, required 0001 0003 0007 000f",
                     seen[0], seen[1], seen[2], seen[3]);
        end
        for (int c = 0; c < 200 && !a_done; c++) step;
        a_sweep(1, 0, -1, 1);
    endtask

    task automatic test_backpressure;
        a_sweep(2, 1, 3, 0);
    endtask

    task automatic test_mid_reset;
        a_mode = 0;
        a_ready = 1'b1;
        a_start = 1'b1;
        step;
        a_start = 1'b0;
        for (int c = 0; c < 200 && a_cnt !== 6'd7; c++) step;
        checks++;
        if (a_cnt !== 6'd7) begin
            errors++;
            $display("FAIL midreset_reach: cnt=%0d, required 7", a_cnt);
        end
        reset = 1'b1;
        step;
        reset = 1'b0;
        checks++;
        if (a_dut_n !== 0 || a_valid !== 0 || a_pat !== 0 || a_rresp !== 0
            || a_sig !== 0 || a_cnt !== 0 || a_busy !== 0 || a_done !== 0) begin
            errors++;
            $display("FAIL midreset_vals: dut_n=%0d valid=%b pat=%0d sig=%h cnt=%0d busy=%b done=%b, required all 0",
                     a_dut_n, a_valid, a_pat, a_sig, a_cnt, a_busy, a_done);
        end
        step;
        checks++;
        if (a_busy !== 0 || a_valid !== 0) begin
            errors++;
            $display("FAIL midreset_idle: busy=%b valid=%b, required 0 0", a_busy, a_valid);
        end
        a_sweep(2, 0, -1, 1);
    endtask

    task automatic test_abort;
        logic [15:0] es = '0;
        a_mode = 3;
        a_lut = $urandom;
        a_start = 1'b1;
        step;
        a_start = 1'b0;
        for (int c = 0; c < 400 && !(a_dut_n == 5'd9 && !a_valid); c++) begin
            a_ready = 1'($urandom_range(0, 1));
            step;
        end
        a_ready = 1'b1;
        for (int p = 0; p < 9; p++) es = misr(es, ref_a(3, p));
        a_abort = 1'b1;
        a_start = 1'b1;
        step;
        a_abort = 1'b0;
        a_start = 1'b0;
        checks++;
        if (a_busy !== 0 || a_done !== 0 || a_valid !== 0 || a_cnt !== 6'd9
            || a_dut_n !== 5'd9 || a_sig !== es) begin
            errors++;
            $display("FAIL abort_hold: busy=%b done=%b valid=%b cnt=%0d dut_n=%0d sig=%h, required 0 0 0 9 9 %h",
                     a_busy, a_done, a_valid, a_cnt, a_dut_n, a_sig, es);
        end
        step;
        checks++;
        if (a_busy !== 0 || a_dut_n !== 5'd9) begin
            errors++;
            $display("FAIL abort_start_ignored: busy=%b dut_n=%0d, required 0 9", a_busy, a_dut_n);
        end
        a_sweep(3, 1, -1, 0);
    endtask

    task automatic test_settle4;
        int acc = 0, ep = 0, chg = 0;
        logic [15:0] es = '0;
        logic pv = 1'b0;
        logic [BW-1:0] pdn;
        foreach (b_lut[i]) b_lut[i] = BO'($urandom);
        b_start = 1'b1;
        step;
        b_start = 1'b0;
        cyc = 0;
        pdn = b_dut_n;
        while (!b_done && cyc < 1000) begin
            if (b_dut_n !== pdn) begin
                chg = cyc;
                pdn = b_dut_n;
            end
            if (b_valid && !pv) begin
                checks++;
                if (cyc - chg != BS + 1) begin
                    errors++;
                    $display("FAIL settle_lat_b: %0d cycles, required %0d", cyc - chg, BS + 1);
                end
            end
            b_ready = 1'($urandom_range(0, 1));
            if (b_valid && b_ready) begin
                es = misr(es, int'(b_lut[ep]));
                checks++;
                if (b_pat !== BW'(ep) || b_rresp !== b_lut[ep] || b_sig !== es || b_cnt !== (BW+1)'(acc)) begin
                    errors++;
                    $display("FAIL record_b: pat=%0d resp=%h sig=%h cnt=%0d, required %0d %h %h %0d",
                             b_pat, b_rresp, b_sig, b_cnt, ep, b_lut[ep], es, acc);
                end
                acc++;
                ep++;
            end
            pv = b_valid;
            step;
        end
        b_ready = 1'b1;
        checks++;
        if (b_done !== 1 || b_busy !== 0 || b_cnt !== 4'd8 || acc != 8 || b_sig !== es) begin
            errors++;
            $display("FAIL sweep_end_b: done=%b busy=%b cnt=%0d acc=%0d sig=%h, required 1 0 8 8 %h",
                     b_done, b_busy, b_cnt, acc, b_sig, es);
        end
    endtask

    task automatic test_back_to_back;
        a_sweep(3, 1, -1, 0);
        a_sweep(2, 0, -1, 1);
    endtask

    initial begin
        test_reset;
        test_sweep_zero;
        test_sweep_ones;
        test_backpressure;
        test_mid_reset;
        test_abort;
        test_settle4;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
